// File: rtl/uart_rx_deser.sv
// ---------------------------------------------------------------------------
// uart_rx_deser
//   UART 8N1 receive deserializer (LSB first). Works alongside an external
//   bit-timing generator: it synchronizes the raw line and hands it to the
//   generator as start_n. It then uses the generator's bit-boundary ticks to
//   sample each bit half a bit period later. Completed bytes are presented
//   through a one-entry valid/ready holding register.
//
// Ports
//   clk_50M    in   system clock
//   reset_n    in   asynchronous active-low reset
//   rxd        in   raw serial line (idle high, asynchronous)
//   tick       in   one-cycle bit-boundary pulse from the generator
//   ticked     in   generator bit index, valid while tick=1
//   full       in   generator idle flag (1 = not counting)
//   start_n    out  synchronized rxd, drives the generator start input
//   rx_data    out  received byte, stable while rx_valid=1
//   rx_valid   out  byte available
//   rx_ready   in   consumer accepts on rx_valid & rx_ready
//   frame_err  out  sticky: stop bit sampled low
//   overrun    out  sticky: byte completed while holding register full
//   err_clr    in   one-cycle clear of frame_err / overrun
//   busy       out  receiver FSM not idle
// ---------------------------------------------------------------------------
module uart_rx_deser #(
  parameter int unsigned HALF_BIT = 2604
) (
  input  logic       clk_50M,
  input  logic       reset_n,
  input  logic       rxd,
  input  logic       tick,
  input  logic [3:0] ticked,
  input  logic       full,
  output logic       start_n,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    FRAME     = 3'd2,
    DELIVER   = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  localparam logic [12:0] TIMER_LOAD = 13'(HALF_BIT - 1);

  state_t      state_r;
  state_t      state_next_s;

  logic        sync1_r;
  logic        sync2_r;
  logic [12:0] timer_r;
  logic        timer_run_r;
  logic [3:0]  bit_idx_r;
  logic [7:0]  sr_r;
  logic [7:0]  rx_data_r;
  logic        rx_valid_r;
  logic        frame_err_r;
  logic        overrun_r;
  logic        busy_r;

  logic        sample_pt_s;
  logic        timer_load_s;
  logic        accept_s;
  logic        shift_s;
  logic        load_data_s;
  logic        set_ferr_s;
  logic        set_ovr_s;

  assign start_n   = sync2_r;
  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;
  assign busy      = busy_r;

  // The sample point is the last cycle of a running half-bit countdown.
  assign sample_pt_s  = timer_run_r && (timer_r == 13'd0);
  // Ticks only matter while a frame is in progress; idle and recovery ignore them.
  assign timer_load_s = tick && (state_r != IDLE) && (state_r != WAIT_IDLE);
  assign accept_s     = rx_valid_r && rx_ready;

  // Two-flop synchronizer on the raw line; resets to the idle (high) level.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rxd;
      sync2_r <= sync1_r;
    end
  end

  // Half-bit sample timer, restarted by every relevant tick together with the bit index.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      timer_r     <= 13'd0;
      timer_run_r <= 1'b0;
      bit_idx_r   <= 4'd0;
    end else if (timer_load_s) begin
      timer_r     <= TIMER_LOAD;
      timer_run_r <= 1'b1;
      bit_idx_r   <= ticked;
    end else if (timer_run_r) begin
      if (timer_r == 13'd0) begin
        timer_run_r <= 1'b0;
      end else begin
        timer_r <= timer_r - 13'd1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state and per-cycle datapath strobes.
  always_comb begin
    state_next_s = state_r;
    shift_s      = 1'b0;
    load_data_s  = 1'b0;
    set_ferr_s   = 1'b0;
    set_ovr_s    = 1'b0;
    case (state_r)
      IDLE: begin
        // Start only on a low line with the generator ready to count.
        if (!sync2_r && full) begin
          state_next_s = ARMED;
        end else begin
          state_next_s = IDLE;
        end
      end
      ARMED: begin
        if (tick && (ticked == 4'd0)) begin
          state_next_s = FRAME;
        end else begin
          state_next_s = ARMED;
        end
      end
      FRAME: begin
        if (sample_pt_s) begin
          case (bit_idx_r)
            4'd0: begin
              // A start bit that is high at mid-bit was a glitch.
              if (sync2_r) begin
                state_next_s = WAIT_IDLE;
              end else begin
                state_next_s = FRAME;
              end
            end
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
              shift_s = 1'b1;
            end
            4'd9: begin
              if (sync2_r) begin
                state_next_s = DELIVER;
              end else begin
                set_ferr_s   = 1'b1;
                state_next_s = WAIT_IDLE;
              end
            end
            default: begin
              state_next_s = FRAME;
            end
          endcase
        end else begin
          state_next_s = FRAME;
        end
      end
      DELIVER: begin
        // A same-cycle accept frees the holding register for the new byte.
        if (!rx_valid_r || accept_s) begin
          load_data_s = 1'b1;
        end else begin
          set_ovr_s = 1'b1;
        end
        state_next_s = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        // Hold off until the line is high and the generator has stopped, so a
        // stuck-low line or trailing ticks cannot restart reception.
        if (full && sync2_r) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT_IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Data bits enter at the MSB so that after eight shifts bit 0 holds the first bit.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      sr_r <= 8'h00;
    end else if (shift_s) begin
      sr_r <= {sync2_r, sr_r[7:1]};
    end
  end

  // Holding register and handshake; a reload takes priority over the accept-clear.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      rx_data_r  <= 8'h00;
      rx_valid_r <= 1'b0;
    end else if (load_data_s) begin
      rx_data_r  <= sr_r;
      rx_valid_r <= 1'b1;
    end else if (accept_s) begin
      rx_valid_r <= 1'b0;
    end
  end

  // Sticky error flags; a new error in the same cycle as err_clr wins.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      if (set_ferr_s) begin
        frame_err_r <= 1'b1;
      end else if (err_clr) begin
        frame_err_r <= 1'b0;
      end
      if (set_ovr_s) begin
        overrun_r <= 1'b1;
      end else if (err_clr) begin
        overrun_r <= 1'b0;
      end
    end
  end

  // Busy is registered from the next state so it tracks the FSM without a lag.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_deser.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deser
//   Bench for uart_rx_deser with a behavioural bit-timing generator. The bit
//   period is scaled down (BIT cycles per bit, HALF cycles to mid-bit) to keep
//   the run short. Expected bytes are queued by the stimulus. A monitor pops
//   and compares them whenever the DUT hands a byte over.
// ---------------------------------------------------------------------------
module tb_uart_rx_deser;

  localparam int BIT  = 33;
  localparam int HALF = 16;

  logic       clk_50M = 1'b0;
  logic       reset_n = 1'b0;
  logic       gen_rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       tick;
  logic [3:0] ticked;
  logic       full;
  logic       start_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       frame_err;
  logic       overrun;
  logic       err_clr = 1'b0;
  logic       busy;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];

  logic [7:0] gcnt;
  logic [3:0] gidx;
  logic       prev_hold;
  logic [7:0] prev_data;

  uart_rx_deser #(.HALF_BIT(HALF)) dut (
    .clk_50M  (clk_50M),
    .reset_n  (reset_n),
    .rxd      (rxd),
    .tick     (tick),
    .ticked   (ticked),
    .full     (full),
    .start_n  (start_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .err_clr  (err_clr),
    .busy     (busy)
  );

  always #10 clk_50M = ~clk_50M;

  // Timing generator model: starts on start_n low while idle, then ticks at
  // every bit boundary (index 0..10) and goes idle with the index-10 tick.
  always @(posedge clk_50M or negedge gen_rst_n) begin
    if (!gen_rst_n) begin
      full   <= 1'b1;
      tick   <= 1'b0;
      ticked <= 4'd0;
      gcnt   <= 8'd0;
      gidx   <= 4'd0;
    end else begin
      tick <= 1'b0;
      if (full) begin
        if (!start_n) begin
          full <= 1'b0;
          gcnt <= 8'd0;
          gidx <= 4'd0;
        end
      end else begin
        if (gcnt == 8'd0) begin
          tick   <= 1'b1;
          ticked <= gidx;
          gidx   <= gidx + 4'd1;
          if (gidx == 4'd10) full <= 1'b1;
        end
        gcnt <= (gcnt == 8'(BIT - 1)) ? 8'd0 : gcnt + 8'd1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every handover is checked against the queue head; data must
  // stay stable while a byte is held and not yet taken.
  always @(negedge clk_50M) begin
    if (reset_n) begin
      if (prev_hold && rx_valid) begin
        check("rx_data_stable", {24'd0, rx_data}, {24'd0, prev_data});
      end
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'd0, rx_data}, 32'hFFFF_FFFF);
        end else begin
          check("rx_byte", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        end
      end
      prev_hold = rx_valid && !rx_ready;
      prev_data = rx_data;
    end else begin
      prev_hold = 1'b0;
      prev_data = 8'h00;
    end
  end

  task automatic drive_bit(input logic b, input int cycles);
    rxd = b;
    repeat (cycles) @(negedge clk_50M);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BIT);
    drive_bit(stop_bit, BIT);
    rxd = 1'b1;
  endtask

  // Wait for the generator to return idle, bounded; leaves a short idle gap.
  task automatic wait_full(input string name);
    int n;
    n = 0;
    repeat (5) @(negedge clk_50M);
    while (!full && n < 12 * BIT) begin
      @(negedge clk_50M);
      n++;
    end
    check({name, "_gen_idle_timeout"}, {31'd0, full}, 32'd1);
    repeat (4) @(negedge clk_50M);
  endtask

  initial begin
    repeat (3) @(negedge clk_50M);
    gen_rst_n = 1'b1;
    // Reset state
    check("rst_start_n", {31'd0, start_n}, 32'd1);
    check("rst_rx_data", {24'd0, rx_data}, 32'h00);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_flags", {30'd0, frame_err, overrun}, 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk_50M);

    // Plain frame 0xA5
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_full("a5");
    check("a5_flags", {30'd0, frame_err, overrun}, 32'd0);
    check("a5_valid_pulse", {31'd0, rx_valid}, 32'd0);

    // Short low glitch: false start, then a good 0x3C
    drive_bit(1'b0, 6);
    rxd = 1'b1;
    @(negedge clk_50M);
    check("glitch_busy_set", {31'd0, busy}, 32'd1);
    wait_full("glitch");
    check("glitch_busy_clear", {31'd0, busy}, 32'd0);
    check("glitch_frame_err", {31'd0, frame_err}, 32'd0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_full("3c");

    // Framing error on 0x5A, then clear
    send_frame(8'h5A, 1'b0);
    wait_full("5a");
    check("ferr_set", {31'd0, frame_err}, 32'd1);
    check("ferr_no_valid", {31'd0, rx_valid}, 32'd0);
    err_clr = 1'b1;
    @(negedge clk_50M);
    err_clr = 1'b0;
    @(negedge clk_50M);
    check("ferr_cleared", {31'd0, frame_err}, 32'd0);

    // Overrun: 0x11 held, 0x22 dropped
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    wait_full("11");
    send_frame(8'h22, 1'b1);
    wait_full("22");
    check("ovr_set", {31'd0, overrun}, 32'd1);
    check("ovr_valid_held", {31'd0, rx_valid}, 32'd1);
    check("ovr_data_kept", {24'd0, rx_data}, 32'h11);
    @(posedge clk_50M);
    #2 rx_ready = 1'b1;
    @(negedge clk_50M);
    @(negedge clk_50M);
    check("ovr_valid_drop", {31'd0, rx_valid}, 32'd0);
    err_clr = 1'b1;
    @(negedge clk_50M);
    err_clr = 1'b0;
    @(negedge clk_50M);
    check("ovr_cleared", {31'd0, overrun}, 32'd0);

    // Reset during data bit 4 of a 0x00 frame, then 0x7E
    for (int i = 0; i < 5; i++) drive_bit(1'b0, BIT);
    drive_bit(1'b0, HALF);
    check("mid_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_start_n", {31'd0, start_n}, 32'd1);
    check("mid_rst_rx_data", {24'd0, rx_data}, 32'h00);
    check("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    repeat (10) @(negedge clk_50M);
    reset_n = 1'b1;
    drive_bit(1'b0, BIT - HALF);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, BIT);
    drive_bit(1'b1, BIT);
    wait_full("mid");
    check("mid_no_busy", {31'd0, busy}, 32'd0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    wait_full("7e");

    // Back-to-back 0x00, 0xFF with a one-bit idle gap
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    drive_bit(1'b1, BIT);
    send_frame(8'hFF, 1'b1);
    wait_full("b2b");
    check("b2b_flags", {30'd0, frame_err, overrun}, 32'd0);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
